// File: rtl/mem_queue_ctrl_pkg.sv
// Shared types and constants for the mem_queue front-end controller:
// entry layout {id[3:0], op[1:0], addr[31:0]}, op codes and service FSM states.
package mem_queue_ctrl_pkg;

  localparam int NUM_REQ        = 4;
  localparam int ID_WIDTH       = 2;
  localparam int ENTRY_ID_WIDTH = 4;
  localparam int OP_WIDTH       = 2;
  localparam int ADDR_WIDTH     = 32;
  localparam int REQUEST_SIZE   = 38;
  localparam int DATA_WIDTH     = 128;
  localparam int BEAT_WIDTH     = 32;
  localparam int CYCLE_NUM_DATA = 4;
  localparam int BEAT_CNT_WIDTH = 2;
  localparam int COUNTER_WIDTH  = 10;

  localparam int ADDR_LSB = 0;
  localparam int OP_LSB   = 32;
  localparam int ID_LSB   = 34;

  localparam logic [OP_WIDTH-1:0] OP_READ  = 2'b00;
  localparam logic [OP_WIDTH-1:0] OP_WRITE = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_LAT,
    ST_XFER,
    ST_ACK
  } state_t;

  typedef struct packed {
    logic [ENTRY_ID_WIDTH-1:0] id;
    logic [OP_WIDTH-1:0]       op;
    logic [ADDR_WIDTH-1:0]     addr;
  } entry_t;

  // A programmed latency of zero still costs one modelled DRAM cycle.
  function automatic logic [COUNTER_WIDTH-1:0] clamp_lat(input logic [COUNTER_WIDTH-1:0] lat);
    return (lat == '0) ? COUNTER_WIDTH'(1) : lat;
  endfunction

endpackage

// File: rtl/mem_queue_ctrl_rr_arbiter.sv
// Single-grant requester arbiter: round-robin from a rotating pointer by default,
// fixed lowest-index priority when MEM_QUEUE_CTRL_FIXED_PRIO_EN is defined.
module mem_queue_ctrl_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_ptr;

`ifdef MEM_QUEUE_CTRL_FIXED_PRIO_EN
  logic w_unused_clk;
  assign w_unused_clk = clk ^ rst_n;
  assign w_ptr        = '0;
`else
  logic [IW-1:0] r_ptr;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // NOTE: defaults at the top of every combinational block keep it free of latches.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(w_ptr) + i) % N);
      if (!o_any && i_req[cand]) begin
        o_any         = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mem_queue_ctrl.sv
// Front-end for mem_queue: arbitrates requesters into the push port and services the head
// entry with a latency-modelling FSM. Optional MEM_QUEUE_CTRL_FIXED_PRIO_EN selects fixed priority.
module mem_queue_ctrl
  import mem_queue_ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [OP_WIDTH*NUM_REQ-1:0]    i_req_op,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]  i_req_addr,
  output logic [NUM_REQ-1:0]             o_req_grant,
  output logic                           o_q_push_en,
  output logic [OP_WIDTH-1:0]            o_q_op,
  output logic [REQUEST_SIZE-1:0]        o_q_buf_in,
  output logic                           o_q_pop_en,
  input  logic [REQUEST_SIZE-1:0]        i_q_buf_out,
  input  logic                           i_q_valid_output,
  input  logic                           i_q_full,
  input  logic                           i_q_empty,
  input  logic [COUNTER_WIDTH-1:0]       i_mem_lat,
  input  logic [DATA_WIDTH-1:0]          i_mem_rdata,
  output logic                           o_resp_valid,
  output logic [ENTRY_ID_WIDTH-1:0]      o_resp_id,
  output logic [BEAT_WIDTH-1:0]          o_resp_data,
  output logic                           o_resp_last,
  output logic                           o_wr_ack,
  output logic                           o_busy
);

  // Push side: grants are combinational and suppressed while reset is asserted.
  logic [NUM_REQ-1:0]    w_req;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_idx;
  logic                  w_any;
  logic [OP_WIDTH-1:0]   w_op;
  logic [ADDR_WIDTH-1:0] w_addr;
  entry_t                w_entry;

  assign w_req = (rst_n && !i_q_full) ? i_req_valid : '0;

  mem_queue_ctrl_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (w_req),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_op   = i_req_op[{w_idx, 1'b0} +: OP_WIDTH];
  assign w_addr = i_req_addr[{w_idx, 5'b0} +: ADDR_WIDTH];

  always_comb begin
    w_entry.id   = ENTRY_ID_WIDTH'(w_idx);
    w_entry.op   = w_op;
    w_entry.addr = w_addr;
  end

  assign o_req_grant = w_grant;
  assign o_q_push_en = w_any;
  assign o_q_op      = w_any ? w_op : '0;
  assign o_q_buf_in  = w_any ? w_entry : '0;

  // Service side.
  state_t                    r_state;
  state_t                    w_next;
  logic [COUNTER_WIDTH-1:0]  r_lat_cnt;
  logic [BEAT_CNT_WIDTH-1:0] r_beat;
  logic [ENTRY_ID_WIDTH-1:0] r_id;
  logic [OP_WIDTH-1:0]       r_op;
  logic [DATA_WIDTH-1:0]     r_line;
  logic [BEAT_WIDTH-1:0]     w_beat_word;
  logic                      w_unused_addr;

  // The address is only meaningful to the memory model, not to the response path.
  assign w_unused_addr = ^i_q_buf_out[ADDR_LSB +: ADDR_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (!i_q_empty) w_next = ST_POP;
      ST_POP:  w_next = ST_WAIT;
      ST_WAIT: if (i_q_valid_output) w_next = ST_LAT;
      ST_LAT:  if (r_lat_cnt == COUNTER_WIDTH'(1)) w_next = (r_op == OP_READ) ? ST_XFER : ST_ACK;
      ST_XFER: if (r_beat == BEAT_CNT_WIDTH'(CYCLE_NUM_DATA - 1)) w_next = ST_IDLE;
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so an aborted transfer leaves no stale line or id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt <= '0;
      r_beat    <= '0;
      r_id      <= '0;
      r_op      <= '0;
      r_line    <= '0;
    end else begin
      unique case (r_state)
        ST_POP: begin
          r_lat_cnt <= clamp_lat(i_mem_lat);
          r_beat    <= '0;
        end
        ST_WAIT: begin
          if (i_q_valid_output) begin
            r_id <= i_q_buf_out[ID_LSB +: ENTRY_ID_WIDTH];
            r_op <= i_q_buf_out[OP_LSB +: OP_WIDTH];
          end
        end
        ST_LAT: begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
          if (r_lat_cnt == COUNTER_WIDTH'(1)) r_line <= i_mem_rdata;
        end
        ST_XFER: r_beat <= r_beat + 1'b1;
        default: ;
      endcase
    end
  end

  assign w_beat_word = r_line[{r_beat, 5'b0} +: BEAT_WIDTH];

  always_comb begin
    o_q_pop_en   = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_id    = '0;
    o_resp_data  = '0;
    o_resp_last  = 1'b0;
    o_wr_ack     = 1'b0;
    o_busy       = (r_state != ST_IDLE);
    unique case (r_state)
      ST_POP: o_q_pop_en = 1'b1;
      ST_XFER: begin
        o_resp_valid = 1'b1;
        o_resp_id    = r_id;
        o_resp_data  = w_beat_word;
        o_resp_last  = (r_beat == BEAT_CNT_WIDTH'(CYCLE_NUM_DATA - 1));
      end
      ST_ACK: begin
        o_wr_ack  = 1'b1;
        o_resp_id = r_id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_queue_ctrl.sv
// Self-checking bench for mem_queue_ctrl: a behavioural mem_queue stub, a cycle-level
// transaction model compared every cycle, and directed scenarios with literal expectations.
module tb_mem_queue_ctrl;
  import mem_queue_ctrl_pkg::*;

  localparam int DEPTH = 16;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [7:0]   req_op;
  logic [127:0] req_addr;
  logic [3:0]   req_grant;
  logic         q_push_en;
  logic [1:0]   q_op;
  logic [37:0]  q_buf_in;
  logic         q_pop_en;
  logic [37:0]  q_buf_out;
  logic         q_valid_output;
  logic         q_full;
  logic         q_empty;
  logic [9:0]   mem_lat;
  logic [127:0] mem_rdata;
  logic         resp_valid;
  logic [3:0]   resp_id;
  logic [31:0]  resp_data;
  logic         resp_last;
  logic         wr_ack;
  logic         busy;

  logic         force_full;
  logic         stub_full;
  logic [37:0]  stub_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  mem_queue_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (req_valid),
    .i_req_op         (req_op),
    .i_req_addr       (req_addr),
    .o_req_grant      (req_grant),
    .o_q_push_en      (q_push_en),
    .o_q_op           (q_op),
    .o_q_buf_in       (q_buf_in),
    .o_q_pop_en       (q_pop_en),
    .i_q_buf_out      (q_buf_out),
    .i_q_valid_output (q_valid_output),
    .i_q_full         (q_full),
    .i_q_empty        (q_empty),
    .i_mem_lat        (mem_lat),
    .i_mem_rdata      (mem_rdata),
    .o_resp_valid     (resp_valid),
    .o_resp_id        (resp_id),
    .o_resp_data      (resp_data),
    .o_resp_last      (resp_last),
    .o_wr_ack         (wr_ack),
    .o_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign q_full = force_full | stub_full;

  // Behavioural mem_queue: FIFO, registered head output one cycle after pop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_q.delete();
      q_valid_output <= 1'b0;
      q_buf_out      <= '0;
      q_empty        <= 1'b1;
      stub_full      <= 1'b0;
    end else begin
      q_valid_output <= 1'b0;
      if (q_pop_en && stub_q.size() > 0) begin
        q_buf_out      <= stub_q.pop_front();
        q_valid_output <= 1'b1;
      end
      if (q_push_en) stub_q.push_back(q_buf_in);
      q_empty   <= (stub_q.size() == 0);
      stub_full <= (stub_q.size() >= DEPTH);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: arbitration from the rotating pointer, one service at a time,
  // first beat 2+max(lat,1) cycles after the pop, next pop only after an idle cycle.
  initial begin : model
    int           cyc;
    int           rr_m;
    logic [37:0]  mq[$];
    bit           svc_on;
    int           svc_pop;
    int           svc_lat;
    logic [1:0]   svc_op;
    logic [3:0]   svc_id;
    logic [127:0] svc_line;
    bit           prev_idle;
    bit           prev_ne;
    cyc = 0; rr_m = 0; svc_on = 0; svc_pop = 0; svc_lat = 1;
    svc_op = '0; svc_id = '0; svc_line = '0; prev_idle = 1; prev_ne = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs",
              {req_grant, q_push_en, q_op, q_buf_in, q_pop_en, resp_valid,
               resp_id, resp_data, resp_last, wr_ack, busy}, '0);
        mq.delete();
        rr_m = 0; svc_on = 0; prev_idle = 1; prev_ne = 0;
      end else begin
        logic [3:0]  e_grant;
        logic        e_push;
        logic [1:0]  e_op;
        logic [37:0] e_buf;
        logic        e_pop;
        logic        e_rv;
        logic [3:0]  e_rid;
        logic [31:0] e_rd;
        logic        e_rl;
        logic        e_ack;
        logic        e_busy;
        bit          done;
        int          gsel;
        e_grant = '0; e_push = 0; e_op = '0; e_buf = '0; gsel = -1;
        if (|req_valid && !q_full) begin
          for (int k = 0; k < 4; k++) begin
            int j;
            j = (rr_m + k) % 4;
            if (gsel < 0 && req_valid[j]) gsel = j;
          end
          e_grant[gsel] = 1'b1;
          e_push        = 1'b1;
          e_op          = req_op[2*gsel +: 2];
          e_buf         = {2'b00, 2'(gsel), e_op, req_addr[32*gsel +: 32]};
        end

        e_pop = prev_idle && prev_ne;
        if (e_pop) begin
          logic [37:0] ent;
          ent     = mq.pop_front();
          svc_on  = 1;
          svc_pop = cyc;
          svc_lat = (mem_lat == 0) ? 1 : int'(mem_lat);
          svc_id  = ent[37:34];
          svc_op  = ent[33:32];
        end

        e_busy = svc_on; e_rv = 0; e_rid = '0; e_rd = '0; e_rl = 0; e_ack = 0; done = 0;
        if (svc_on) begin
          int d;
          d = cyc - svc_pop;
          if (d == 1 + svc_lat) svc_line = mem_rdata;
          if (svc_op == 2'b00) begin
            if (d >= 2 + svc_lat) begin
              int b;
              b     = d - 2 - svc_lat;
              e_rv  = 1;
              e_rid = svc_id;
              e_rd  = svc_line[32*b +: 32];
              e_rl  = (b == 3);
              done  = (b == 3);
            end
          end else if (d == 2 + svc_lat) begin
            e_ack = 1;
            e_rid = svc_id;
            done  = 1;
          end
        end

        check("req_grant",  req_grant,  e_grant);
        check("q_push_en",  q_push_en,  e_push);
        check("q_op",       q_op,       e_op);
        check("q_buf_in",   q_buf_in,   e_buf);
        check("q_pop_en",   q_pop_en,   e_pop);
        check("busy",       busy,       e_busy);
        check("resp_valid", resp_valid, e_rv);
        check("resp_id",    resp_id,    e_rid);
        check("resp_data",  resp_data,  e_rd);
        check("resp_last",  resp_last,  e_rl);
        check("wr_ack",     wr_ack,     e_ack);

        prev_idle = !svc_on;
        prev_ne   = (mq.size() > 0);
        if (done) svc_on = 0;
        if (e_push) begin
          mq.push_back(e_buf);
          rr_m = (gsel + 1) % 4;
        end
      end
      cyc++;
    end
  end

  task automatic drain();
    int quiet;
    quiet = 0;
    for (int n = 0; n < 400 && quiet < 2; n++) begin
      @(negedge clk);
      if (!busy && q_empty) quiet++;
      else quiet = 0;
    end
    check("drain_idle", 128'(quiet >= 2), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_pop();
    bit seen;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (q_pop_en) seen = 1;
    end
    check("pop_seen", seen, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] beats[4];
    int          n_ack;
    int          ack_at;
    bit          rv_seen;
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_op     = '0;
    req_addr   = '0;
    force_full = 1'b0;
    mem_lat    = 10'd3;
    mem_rdata  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    // 1: reset holds grants and outputs low even with all requesters valid
    repeat (3) begin
      @(negedge clk);
      check("t1_grant", req_grant, 4'b0000);
      check("t1_push",  q_push_en, 1'b0);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = 4'h0;

    // 2: round-robin rotation across all four requesters
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) req_addr[32*i +: 32] = 32'h1000_0000 + 32'(i);
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_grant", req_grant, 4'b0001 << i);
      check("t2_id",    q_buf_in[37:34], 4'(i));
    end
    @(posedge clk); #1;
    req_valid = 4'h0;
    drain();

    // 3: read line, latency 5, four beats low word first
    req_op[1:0]    = 2'b00;
    req_addr[31:0] = 32'h2222_0000;
    mem_lat        = 10'd5;
    mem_rdata      = 128'hCCDDEEFF_99AABB00_55667788_11223344;
    beats[0] = 32'h11223344; beats[1] = 32'h55667788;
    beats[2] = 32'h99AABB00; beats[3] = 32'hCCDDEEFF;
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = 4'h0;
    wait_pop();
    repeat (6) @(negedge clk);
    check("t3_before_first", resp_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_valid", resp_valid, 1'b1);
      check("t3_data",  resp_data,  beats[k]);
      check("t3_last",  resp_last,  k == 3);
    end
    drain();

    // 4: write from requester 2 with zero latency
    req_op[5:4]     = 2'b01;
    req_addr[95:64] = 32'h0000_0001;
    mem_lat         = 10'd0;
    req_valid       = 4'b0100;
    @(posedge clk); #1;
    req_valid = 4'h0;
    wait_pop();
    n_ack = 0; ack_at = 0; rv_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (wr_ack) begin
        n_ack++;
        ack_at = k;
        check("t4_resp_id", resp_id, 4'd2);
      end
      if (resp_valid) rv_seen = 1;
    end
    check("t4_ack_count", n_ack, 1);
    check("t4_ack_delay", ack_at, 3);
    check("t4_no_beats",  rv_seen, 0);
    drain();

    // 5: full queue blocks grants; requester 0 wins once it drains
    req_op     = '0;
    mem_lat    = 10'd1;
    force_full = 1'b1;
    req_valid  = 4'b0011;
    repeat (3) begin
      @(negedge clk);
      check("t5_blocked", req_grant, 4'b0000);
      check("t5_no_push", q_push_en, 1'b0);
    end
    @(posedge clk); #1;
    force_full = 1'b0;
    @(negedge clk);
    check("t5_grant", req_grant, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'h0;
    drain();

    // 6: reset during the third beat aborts the transfer cleanly
    mem_lat   = 10'd2;
    mem_rdata = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = 4'h0;
    wait_pop();
    repeat (6) @(negedge clk);
    check("t6_beat2_valid", resp_valid, 1'b1);
    check("t6_beat2_data",  resp_data,  32'hCCCC0002);
    #1 rst_n = 1'b0;
    #1;
    check("t6_abort_valid", resp_valid, 1'b0);
    check("t6_abort_busy",  busy,       1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t6_no_stale", {resp_valid, busy, wr_ack}, 3'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
